// File: rtl/mix_sequencer.sv
// mix_sequencer: timed valve sequencer (PRIME -> MIX -> DWELL -> FLUSH -> DONE) for the two-stage diffusion mixer.
// Optional supply-pressure watchdog is compiled in when MIX_SEQ_PRESSURE_CHECK_EN is defined.
module mix_sequencer #(
    parameter int CNT_W = 16,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] t_prime,
    input  logic [CNT_W-1:0] t_mix,
    input  logic [CNT_W-1:0] t_dwell,
    input  logic [CNT_W-1:0] t_flush,
    input  logic             pressure_ok,
    output logic             valve_soln1,
    output logic             valve_soln2,
    output logic             valve_soln3,
    output logic             valve_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [RUN_W-1:0] run_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_MIX   = 3'd2,
        S_DWELL = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    state_t           nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] t_mix_q, t_mix_d;
    logic [CNT_W-1:0] t_dwell_q, t_dwell_d;
    logic [CNT_W-1:0] t_flush_q, t_flush_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic             v3_q, v3_d;
    logic             vo_q, vo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             in_run;
    logic             fault;

    // First phase after 'after' whose duration is nonzero; DONE when all remaining are zero.
    function automatic state_t first_phase(input state_t after,
                                           input logic [CNT_W-1:0] p,
                                           input logic [CNT_W-1:0] m,
                                           input logic [CNT_W-1:0] d,
                                           input logic [CNT_W-1:0] f);
        state_t r;
        r = S_DONE;
        case (after)
            S_IDLE: begin
                if (p != '0)      r = S_PRIME;
                else if (m != '0) r = S_MIX;
                else if (d != '0) r = S_DWELL;
                else if (f != '0) r = S_FLUSH;
            end
            S_PRIME: begin
                if (m != '0)      r = S_MIX;
                else if (d != '0) r = S_DWELL;
                else if (f != '0) r = S_FLUSH;
            end
            S_MIX: begin
                if (d != '0)      r = S_DWELL;
                else if (f != '0) r = S_FLUSH;
            end
            S_DWELL: begin
                if (f != '0)      r = S_FLUSH;
            end
            default: r = S_DONE;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] load_value(input state_t s,
                                                    input logic [CNT_W-1:0] p,
                                                    input logic [CNT_W-1:0] m,
                                                    input logic [CNT_W-1:0] d,
                                                    input logic [CNT_W-1:0] f);
        logic [CNT_W-1:0] r;
        case (s)
            S_PRIME: r = p - CNT_ONE;
            S_MIX:   r = m - CNT_ONE;
            S_DWELL: r = d - CNT_ONE;
            S_FLUSH: r = f - CNT_ONE;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign in_run = (state_q == S_PRIME) || (state_q == S_MIX) ||
                    (state_q == S_DWELL) || (state_q == S_FLUSH);

`ifdef MIX_SEQ_PRESSURE_CHECK_EN
    // Two consecutive low samples in a flowing phase are treated as an abort; DWELL has no flow.
    logic low_q, low_d;

    always_comb begin
        low_d = ((state_q == S_PRIME) || (state_q == S_MIX) || (state_q == S_FLUSH)) && !pressure_ok;
        fault = low_d && low_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_q <= 1'b0;
        end else begin
            low_q <= low_d;
        end
    end
`else
    logic unused_pressure_ok;
    assign unused_pressure_ok = pressure_ok;
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        t_mix_d   = t_mix_q;
        t_dwell_d = t_dwell_q;
        t_flush_d = t_flush_q;
        run_d     = run_q;
        nxt       = S_DONE;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    t_mix_d   = t_mix;
                    t_dwell_d = t_dwell;
                    t_flush_d = t_flush;
                    nxt       = first_phase(S_IDLE, t_prime, t_mix, t_dwell, t_flush);
                    state_d   = nxt;
                    cnt_d     = load_value(nxt, t_prime, t_mix, t_dwell, t_flush);
                end
            end
            S_PRIME, S_MIX, S_DWELL, S_FLUSH: begin
                if (abort || fault) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    nxt     = first_phase(state_q, '0, t_mix_q, t_dwell_q, t_flush_q);
                    state_d = nxt;
                    cnt_d   = load_value(nxt, '0, t_mix_q, t_dwell_q, t_flush_q);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // DONE is only ever one cycle long, so entering it is the completion event.
        if (state_d == S_DONE) begin
            run_d = run_q + RUN_ONE;
        end

        v1_d      = (state_d == S_MIX);
        v2_d      = (state_d == S_PRIME) || (state_d == S_MIX) || (state_d == S_FLUSH);
        v3_d      = (state_d == S_MIX);
        vo_d      = (state_d == S_MIX) || (state_d == S_FLUSH);
        busy_d    = (state_d == S_PRIME) || (state_d == S_MIX) ||
                    (state_d == S_DWELL) || (state_d == S_FLUSH);
        done_d    = (state_d == S_DONE);
        aborted_d = in_run && (abort || fault);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            t_mix_q   <= '0;
            t_dwell_q <= '0;
            t_flush_q <= '0;
            run_q     <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            vo_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            t_mix_q   <= t_mix_d;
            t_dwell_q <= t_dwell_d;
            t_flush_q <= t_flush_d;
            run_q     <= run_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            vo_q      <= vo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign valve_soln1 = v1_q;
    assign valve_soln2 = v2_q;
    assign valve_soln3 = v3_q;
    assign valve_out   = vo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign run_count   = run_q;

endmodule

// File: tb/tb_mix_sequencer.sv
// Directed bench for mix_sequencer; expectations are hand-derived phase tables and a run counter model.
module tb_mix_sequencer;

    localparam int CNT_W = 16;
    localparam int RUN_W = 8;

    // Output bundle order: {soln1, soln2, soln3, out, busy, done, aborted}
    localparam logic [6:0] V_IDLE  = 7'b0000000;
    localparam logic [6:0] V_PRIME = 7'b0100100;
    localparam logic [6:0] V_MIX   = 7'b1111100;
    localparam logic [6:0] V_DWELL = 7'b0000100;
    localparam logic [6:0] V_FLUSH = 7'b0101100;
    localparam logic [6:0] V_DONE  = 7'b0000010;
    localparam logic [6:0] V_ABORT = 7'b0000001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] t_prime;
    logic [CNT_W-1:0] t_mix;
    logic [CNT_W-1:0] t_dwell;
    logic [CNT_W-1:0] t_flush;
    logic             pressure_ok;
    logic             valve_soln1;
    logic             valve_soln2;
    logic             valve_soln3;
    logic             valve_out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [RUN_W-1:0] run_count;
    logic [6:0]       st;

    int               checks = 0;
    int               errors = 0;
    int               busy_cycles = 0;
    logic [RUN_W-1:0] exp_run = '0;

    mix_sequencer #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .t_prime    (t_prime),
        .t_mix      (t_mix),
        .t_dwell    (t_dwell),
        .t_flush    (t_flush),
        .pressure_ok(pressure_ok),
        .valve_soln1(valve_soln1),
        .valve_soln2(valve_soln2),
        .valve_soln3(valve_soln3),
        .valve_out  (valve_out),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .run_count  (run_count)
    );

    always #5 clk = ~clk;

    assign st = {valve_soln1, valve_soln2, valve_soln3, valve_out, busy, done, aborted};

    always @(negedge clk) begin
        if (busy) busy_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [6:0] exp);
        chk(tag, 32'(st), 32'(exp));
    endtask

    task automatic hold(input string tag, input logic [6:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            chk_v(tag, exp);
            tick();
        end
    endtask

    task automatic go(input int p, input int m, input int d, input int f);
        t_prime = CNT_W'(p);
        t_mix   = CNT_W'(m);
        t_dwell = CNT_W'(d);
        t_flush = CNT_W'(f);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        exp_run = exp_run + 1'b1;
        chk_v({tag, "_done"}, V_DONE);
        chk({tag, "_runcnt"}, 32'(run_count), 32'(exp_run));
        tick();
        chk_v({tag, "_idle"}, V_IDLE);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pressure_ok = 1'b1;
        t_prime = '0; t_mix = '0; t_dwell = '0; t_flush = '0;
        #12;
        chk_v("reset_outputs", V_IDLE);
        chk("reset_runcnt", 32'(run_count), 32'd0);
        rst_n = 1'b1;
        tick();
        chk_v("idle_after_reset", V_IDLE);

        // Basic run 3/5/2/4
        busy_cycles = 0;
        go(3, 5, 2, 4);
        hold("t1_prime", V_PRIME, 3);
        hold("t1_mix", V_MIX, 5);
        hold("t1_dwell", V_DWELL, 2);
        hold("t1_flush", V_FLUSH, 4);
        chk("t1_busy_len", 32'(busy_cycles), 32'd14);
        finish_run("t1");

        // Skipped phases, then all zero
        go(0, 2, 0, 1);
        hold("t2_mix", V_MIX, 2);
        hold("t2_flush", V_FLUSH, 1);
        finish_run("t2");
        go(0, 0, 0, 0);
        finish_run("t2_zero");

        // Abort in MIX cycle 2
        go(1, 10, 1, 1);
        hold("t3_prime", V_PRIME, 1);
        hold("t3_mix1", V_MIX, 1);
        abort = 1'b1;
        chk_v("t3_mix2", V_MIX);
        tick();
        abort = 1'b0;
        chk_v("t3_aborted", V_ABORT);
        chk("t3_runcnt", 32'(run_count), 32'(exp_run));
        tick();
        chk_v("t3_idle", V_IDLE);
        go(1, 1, 1, 1);
        hold("t3b_prime", V_PRIME, 1);
        hold("t3b_mix", V_MIX, 1);
        hold("t3b_dwell", V_DWELL, 1);
        hold("t3b_flush", V_FLUSH, 1);
        finish_run("t3b");

        // Durations changed and start pulsed during PRIME
        go(3, 5, 2, 4);
        t_mix = 16'd9; t_prime = 16'd7; t_flush = 16'd1;
        start = 1'b1;
        hold("t4_prime", V_PRIME, 3);
        start = 1'b0;
        hold("t4_mix", V_MIX, 5);
        hold("t4_dwell", V_DWELL, 2);
        hold("t4_flush", V_FLUSH, 4);
        finish_run("t4");

        // start with abort in IDLE: nothing happens
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_v("t5_start_abort", V_IDLE);
        tick();
        chk_v("t5_still_idle", V_IDLE);

        // abort during DONE is ignored
        go(0, 0, 0, 0);
        abort = 1'b1;
        exp_run = exp_run + 1'b1;
        chk_v("t6_done", V_DONE);
        chk("t6_runcnt", 32'(run_count), 32'(exp_run));
        tick();
        abort = 1'b0;
        chk_v("t6_no_abort", V_IDLE);
        chk("t6_runcnt_kept", 32'(run_count), 32'(exp_run));

        // Pressure glitch in MIX and low pressure through DWELL
        go(1, 6, 3, 2);
        hold("p1_prime", V_PRIME, 1);
        hold("p1_mix1", V_MIX, 1);
        pressure_ok = 1'b0;
        hold("p1_mix2", V_MIX, 1);
        pressure_ok = 1'b1;
        hold("p1_mix3", V_MIX, 4);
        pressure_ok = 1'b0;
        hold("p1_dwell", V_DWELL, 3);
        pressure_ok = 1'b1;
        hold("p1_flush", V_FLUSH, 2);
        finish_run("p1");

        // Pressure low for two cycles in MIX
        go(1, 6, 3, 2);
        hold("p2_prime", V_PRIME, 1);
        hold("p2_mix1", V_MIX, 1);
        pressure_ok = 1'b0;
        hold("p2_mix2", V_MIX, 2);
        pressure_ok = 1'b1;
`ifdef MIX_SEQ_PRESSURE_CHECK_EN
        chk_v("p2_aborted", V_ABORT);
        chk("p2_runcnt", 32'(run_count), 32'(exp_run));
        tick();
        chk_v("p2_idle", V_IDLE);
`else
        hold("p2_mix4", V_MIX, 3);
        hold("p2_dwell", V_DWELL, 3);
        hold("p2_flush", V_FLUSH, 2);
        finish_run("p2");
`endif

        // 256 back-to-back runs with start held high; run_count wraps
        t_prime = 16'd1; t_mix = '0; t_dwell = '0; t_flush = '0;
        start = 1'b1;
        for (int k = 0; k < 256; k++) begin
            tick();
            chk_v("wrap_prime", V_PRIME);
            tick();
            exp_run = exp_run + 1'b1;
            chk_v("wrap_done", V_DONE);
            chk("wrap_runcnt", 32'(run_count), 32'(exp_run));
            tick();
            chk_v("wrap_idle", V_IDLE);
        end
        start = 1'b0;

        // Asynchronous reset mid-run
        go(2, 5, 1, 1);
        hold("r_prime", V_PRIME, 2);
        chk_v("r_mix", V_MIX);
        #2 rst_n = 1'b0;
        #1;
        chk_v("r_async_close", V_IDLE);
        chk("r_runcnt", 32'(run_count), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk_v("r_idle_after", V_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
